regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Write-port arbiter and hazard scoreboard in front of `register_file`. It accepts write-back requests from two producers: A is the ALU result, B is the memory load. Each request is buffered in a one-entry holding register, and the two are round-robin arbitrated onto the single `Awr`/`Din`/`WrEn` port. The block also tracks pending writes, so decode can stall on read-after-write hazards.

## Interface
No parameters; widths are fixed at 5-bit address and 32-bit data.
- `Clk` input 1: clock, rising edge.
- `Rst_n` input 1: reset, asynchronous, active-low.
- `ReqA_Valid` input 1: requester A offers a write.
- `ReqA_Ready` output 1: A's request is accepted at the edge where Valid&Ready.
- `ReqA_Addr` input 5: A's destination register.
- `ReqA_Data` input 32: A's write data.
- `ReqB_Valid`, `ReqB_Ready`, `ReqB_Addr`, `ReqB_Data`: the same set of signals for requester B.
- `Awr` output 5: register file write address (registered).
- `Din` output 32: register file write data (registered).
- `WrEn` output 1: register file write enable (registered).
- `Adr1` input 5: decode read address 1.
- `Adr2` input 5: decode read address 2.
- `Busy1` output 1: `Adr1` has a pending write and decode must stall.
- `Busy2` output 1: `Adr2` has a pending write and decode must stall.
- `Fwd1` output 1: `Dout1` must be replaced by `Din` this cycle.
- `Fwd2` output 1: `Dout2` must be replaced by `Din` this cycle.
- `Pending` output 32: scoreboard; bit n set means a write to Rn is in flight.

## Operation
- **Holding buffers.** Each requester has a one-entry buffer (full flag, addr, data).
  - `ReqX_Ready = (~fullX | grantX) & ~Pending[ReqX_Addr] & ~blockX`.
  - `blockB` = A is accepted in the same cycle with the same non-zero address.
  - `blockA` = 0.
  - Result: a write to an address already in flight is refused, which enforces WAW order.
- **Accept.** On accept, the buffer loads and `Pending[addr]` is set. Address 0 is accepted and buffered, but never sets `Pending`.
- **Arbitration.** Combinational, on buffer full flags only.
  - Both buffers full: grant the side named by pointer `rr`.
  - One buffer full: grant that side.
  - After any grant, `rr` points to the other side.
- **Write stage.** At the edge, the granted entry moves to `Awr`/`Din`, and its buffer is freed unless it is refilled at the same edge. `WrEn` = 1 if the entry's address ≠ 0, otherwise 0. With no grant, `WrEn` = 0 and `Awr`/`Din` hold their values.
- **Retire.** At the edge where `WrEn` = 1, `register_file` writes and `Pending[Awr]` clears. Set and clear of the same bit never coincide, because of the Ready rule.
- **Hazard outputs.** `Busy1 = Pending[Adr1]` and `Busy2 = Pending[Adr2]`. Adr = 0 is never busy.

## Timing
- **Reset values.** Both buffers empty, `rr` = A, `WrEn` = 0, `Awr` = 0, `Din` = 0, `Pending` = 0, `Fwd1`/`Fwd2` = 0. Assertion mid-operation discards all buffered and staged writes immediately.
- **Latency.** Accept at edge k; `WrEn` is high in cycle k+1; the register is written and `Pending` cleared at edge k+2.
- **Throughput.** One write per cycle sustained, including back-to-back writes from one requester to different addresses.
- **Fairness.** With both requesters continuously valid, grants alternate A, B, A, B…

## Configuration
- `WB_BYPASS_EN` defined:
  - `Fwd1 = WrEn & (Awr == Adr1) & (Adr1 != 0)`; `Fwd2` likewise for `Adr2`.
  - `Busy1`/`Busy2` are suppressed when the corresponding `Fwd` is high.
  - Effect: decode consumes `Din` in the write cycle instead of stalling one extra cycle.
- `WB_BYPASS_EN` undefined: `Fwd1` = `Fwd2` = 0, and `Busy` follows `Pending` only.

## Test plan
- **Single write.** A writes R5 = 0xDEADBEEF at edge 0 → `Pending[5]` = 1 at edge 0; `WrEn` = 1, `Awr` = 5, `Din` = 0xDEADBEEF in cycle 1; `Pending[5]` = 0 after edge 2.
- **Simultaneous requests.** A→R3 = 1 and B→R4 = 2 valid together from reset → A granted first, B next cycle; `rr` alternates over 6 continuous requests per side: A, B, A, B, A, B.
- **WAW stall.** A→R7 is pending and B offers R7 → `ReqB_Ready` = 0 until `Pending[7]` clears; B's write then lands after A's. Same-cycle A→R9 and B→R9 → A accepted, B stalled.
- **R0 write.** A→R0 = 0xFFFFFFFF → accepted; `WrEn` stays 0; `Pending` stays 0; `Busy1` = 0 for `Adr1` = 0.
- **Bypass.** `Adr1` = 5 during R5 write stage → with `WB_BYPASS_EN`: `Fwd1` = 1, `Busy1` = 0; without it: `Busy1` = 1, `Fwd1` = 0.
- **Reset mid-operation.** `Rst_n` low with both buffers full and `WrEn` = 1 → all outputs return to reset values asynchronously; `Pending` = 0; no write is issued after release.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Round-robin write-port arbiter for two write-back producers,
//               with a pending-write scoreboard for decode hazard detection.
//               Optional macro: WB_BYPASS_EN (forward Din during write stage).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        ReqA_Valid,
    output logic        ReqA_Ready,
    input  logic [4:0]  ReqA_Addr,
    input  logic [31:0] ReqA_Data,
    input  logic        ReqB_Valid,
    output logic        ReqB_Ready,
    input  logic [4:0]  ReqB_Addr,
    input  logic [31:0] ReqB_Data,
    output logic [4:0]  Awr,
    output logic [31:0] Din,
    output logic        WrEn,
    input  logic [4:0]  Adr1,
    input  logic [4:0]  Adr2,
    output logic        Busy1,
    output logic        Busy2,
    output logic        Fwd1,
    output logic        Fwd2,
    output logic [31:0] Pending
);

    localparam logic RR_A = 1'b0;
    localparam logic RR_B = 1'b1;

    logic        full_a_q, full_a_d;
    logic [4:0]  addr_a_q;
    logic [31:0] data_a_q;
    logic        full_b_q, full_b_d;
    logic [4:0]  addr_b_q;
    logic [31:0] data_b_q;
    logic        rr_q, rr_d;
    logic [31:0] pending_q, pending_d;
    logic [4:0]  awr_q, awr_d;
    logic [31:0] din_q, din_d;
    logic        wren_q, wren_d;

    logic grant_a, grant_b;
    logic accept_a, accept_b;
    logic block_b;

    always_comb begin
        grant_a    = full_a_q & (~full_b_q | (rr_q == RR_A));
        grant_b    = full_b_q & (~full_a_q | (rr_q == RR_B));
        ReqA_Ready = (~full_a_q | grant_a) & ~pending_q[ReqA_Addr];
        accept_a   = ReqA_Valid & ReqA_Ready;
        // Same-cycle collision on a real register: A wins, B waits for retire.
        block_b    = accept_a & (ReqA_Addr == ReqB_Addr) & (ReqA_Addr != 5'd0);
        ReqB_Ready = (~full_b_q | grant_b) & ~pending_q[ReqB_Addr] & ~block_b;
        accept_b   = ReqB_Valid & ReqB_Ready;
    end

    always_comb begin
        full_a_d = accept_a ? 1'b1 : (grant_a ? 1'b0 : full_a_q);
        full_b_d = accept_b ? 1'b1 : (grant_b ? 1'b0 : full_b_q);

        rr_d   = rr_q;
        awr_d  = awr_q;
        din_d  = din_q;
        wren_d = 1'b0;
        if (grant_a) begin
            rr_d   = RR_B;
            awr_d  = addr_a_q;
            din_d  = data_a_q;
            wren_d = (addr_a_q != 5'd0);
        end else if (grant_b) begin
            rr_d   = RR_A;
            awr_d  = addr_b_q;
            din_d  = data_b_q;
            wren_d = (addr_b_q != 5'd0);
        end

        // Retire-clear and accept-set never target the same bit: a pending
        // address is never Ready.
        pending_d = pending_q;
        if (wren_q) begin
            pending_d[awr_q] = 1'b0;
        end
        if (accept_a && (ReqA_Addr != 5'd0)) begin
            pending_d[ReqA_Addr] = 1'b1;
        end
        if (accept_b && (ReqB_Addr != 5'd0)) begin
            pending_d[ReqB_Addr] = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            full_a_q  <= 1'b0;
            addr_a_q  <= 5'd0;
            data_a_q  <= 32'd0;
            full_b_q  <= 1'b0;
            addr_b_q  <= 5'd0;
            data_b_q  <= 32'd0;
            rr_q      <= RR_A;
            pending_q <= 32'd0;
            awr_q     <= 5'd0;
            din_q     <= 32'd0;
            wren_q    <= 1'b0;
        end else begin
            full_a_q  <= full_a_d;
            full_b_q  <= full_b_d;
            rr_q      <= rr_d;
            pending_q <= pending_d;
            awr_q     <= awr_d;
            din_q     <= din_d;
            wren_q    <= wren_d;
            if (accept_a) begin
                addr_a_q <= ReqA_Addr;
                data_a_q <= ReqA_Data;
            end
            if (accept_b) begin
                addr_b_q <= ReqB_Addr;
                data_b_q <= ReqB_Data;
            end
        end
    end

    assign Awr     = awr_q;
    assign Din     = din_q;
    assign WrEn    = wren_q;
    assign Pending = pending_q;

`ifdef WB_BYPASS_EN
    assign Fwd1 = wren_q & (awr_q == Adr1) & (Adr1 != 5'd0);
    assign Fwd2 = wren_q & (awr_q == Adr2) & (Adr2 != 5'd0);
`else
    assign Fwd1 = 1'b0;
    assign Fwd2 = 1'b0;
`endif

    // Bit 0 of the scoreboard is never set, so R0 is never busy.
    assign Busy1 = pending_q[Adr1] & ~Fwd1;
    assign Busy2 = pending_q[Adr2] & ~Fwd2;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Directed self-checking bench for regfile_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    logic        Clk;
    logic        Rst_n;
    logic        ReqA_Valid, ReqA_Ready;
    logic [4:0]  ReqA_Addr;
    logic [31:0] ReqA_Data;
    logic        ReqB_Valid, ReqB_Ready;
    logic [4:0]  ReqB_Addr;
    logic [31:0] ReqB_Data;
    logic [4:0]  Awr;
    logic [31:0] Din;
    logic        WrEn;
    logic [4:0]  Adr1, Adr2;
    logic        Busy1, Busy2, Fwd1, Fwd2;
    logic [31:0] Pending;

    int n_total;
    int n_bad;

    regfile_write_arbiter u_dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .ReqA_Valid (ReqA_Valid),
        .ReqA_Ready (ReqA_Ready),
        .ReqA_Addr  (ReqA_Addr),
        .ReqA_Data  (ReqA_Data),
        .ReqB_Valid (ReqB_Valid),
        .ReqB_Ready (ReqB_Ready),
        .ReqB_Addr  (ReqB_Addr),
        .ReqB_Data  (ReqB_Data),
        .Awr        (Awr),
        .Din        (Din),
        .WrEn       (WrEn),
        .Adr1       (Adr1),
        .Adr2       (Adr2),
        .Busy1      (Busy1),
        .Busy2      (Busy2),
        .Fwd1       (Fwd1),
        .Fwd2       (Fwd2),
        .Pending    (Pending)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic idle_reqs();
        ReqA_Valid = 1'b0;
        ReqB_Valid = 1'b0;
        ReqA_Addr  = 5'd0;
        ReqB_Addr  = 5'd0;
        ReqA_Data  = 32'd0;
        ReqB_Data  = 32'd0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst_n = 1'b0;
        idle_reqs();
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    initial begin
        int ia, ib, nw;
        logic acc_a, acc_b;
        logic byp;
        n_total = 0;
        n_bad   = 0;
`ifdef WB_BYPASS_EN
        byp = 1'b1;
`else
        byp = 1'b0;
`endif
        Rst_n = 1'b0;
        idle_reqs();
        Adr1 = 5'd0;
        Adr2 = 5'd0;

        // Reset state
        #2;
        chk("rst_wren", {31'd0, WrEn}, 32'd0);
        chk("rst_awr", {27'd0, Awr}, 32'd0);
        chk("rst_din", Din, 32'd0);
        chk("rst_pending", Pending, 32'd0);
        chk("rst_fwd", {30'd0, Fwd1, Fwd2}, 32'd0);
        chk("rst_ready", {30'd0, ReqA_Ready, ReqB_Ready}, 32'd3);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Single write of R5
        @(negedge Clk);
        ReqA_Valid = 1'b1; ReqA_Addr = 5'd5; ReqA_Data = 32'hDEADBEEF;
        Adr1 = 5'd5; Adr2 = 5'd5;
        #1 chk("sw_ready", {31'd0, ReqA_Ready}, 32'd1);
        @(posedge Clk);
        @(negedge Clk);
        ReqA_Valid = 1'b0;
        #1;
        chk("sw_pend_set", Pending, 32'h0000_0020);
        chk("sw_wren_k", {31'd0, WrEn}, 32'd0);
        chk("sw_busy_pre", {30'd0, Busy1, Busy2}, 32'd3);
        @(posedge Clk);
        @(negedge Clk);
        #1;
        chk("sw_wren", {31'd0, WrEn}, 32'd1);
        chk("sw_awr", {27'd0, Awr}, 32'd5);
        chk("sw_din", Din, 32'hDEADBEEF);
        chk("sw_pend_ws", Pending, 32'h0000_0020);
        chk("byp_fwd", {30'd0, Fwd1, Fwd2}, byp ? 32'd3 : 32'd0);
        chk("byp_busy", {30'd0, Busy1, Busy2}, byp ? 32'd0 : 32'd3);
        @(posedge Clk);
        @(negedge Clk);
        #1;
        chk("sw_pend_clr", Pending, 32'd0);
        chk("sw_wren_off", {31'd0, WrEn}, 32'd0);
        chk("sw_busy_post", {30'd0, Busy1, Busy2}, 32'd0);

        // R0 write: buffered and staged but never enabled
        @(negedge Clk);
        ReqA_Valid = 1'b1; ReqA_Addr = 5'd0; ReqA_Data = 32'hFFFFFFFF;
        Adr1 = 5'd0;
        #1 chk("r0_ready", {31'd0, ReqA_Ready}, 32'd1);
        @(posedge Clk);
        @(negedge Clk);
        ReqA_Valid = 1'b0;
        #1 chk("r0_pend", Pending, 32'd0);
        @(posedge Clk);
        @(negedge Clk);
        #1;
        chk("r0_wren", {31'd0, WrEn}, 32'd0);
        chk("r0_din", Din, 32'hFFFFFFFF);
        chk("r0_pend2", Pending, 32'd0);
        chk("r0_busy", {31'd0, Busy1}, 32'd0);

        // Fairness: six requests per side, both continuously valid from reset
        do_reset();
        ia = 0; ib = 0; nw = 0;
        for (int cyc = 0; cyc < 40 && nw < 12; cyc++) begin
            @(negedge Clk);
            if (WrEn) begin
                chk("rr_awr", {27'd0, Awr}, 32'(nw + 3));
                chk("rr_din", Din, 32'(nw + 1));
                nw++;
            end
            ReqA_Valid = (ia < 6);
            ReqA_Addr  = 5'(3 + 2 * ia);
            ReqA_Data  = 32'(2 * ia + 1);
            ReqB_Valid = (ib < 6);
            ReqB_Addr  = 5'(4 + 2 * ib);
            ReqB_Data  = 32'(2 * ib + 2);
            #1;
            acc_a = ReqA_Valid & ReqA_Ready;
            acc_b = ReqB_Valid & ReqB_Ready;
            @(posedge Clk);
            if (acc_a) ia++;
            if (acc_b) ib++;
        end
        chk("rr_count", 32'(nw), 32'd12);
        idle_reqs();
        repeat (3) @(negedge Clk);
        chk("rr_pend_clr", Pending, 32'd0);

        // WAW: B to R7 waits until A's write to R7 retires
        @(negedge Clk);
        ReqA_Valid = 1'b1; ReqA_Addr = 5'd7; ReqA_Data = 32'hAAAA0007;
        #1 chk("waw_a_ready", {31'd0, ReqA_Ready}, 32'd1);
        @(posedge Clk);
        @(negedge Clk);
        ReqA_Valid = 1'b0;
        ReqB_Valid = 1'b1; ReqB_Addr = 5'd7; ReqB_Data = 32'hBBBB0007;
        #1 chk("waw_b_blk0", {31'd0, ReqB_Ready}, 32'd0);
        @(posedge Clk);
        @(negedge Clk);
        #1;
        chk("waw_b_blk1", {31'd0, ReqB_Ready}, 32'd0);
        chk("waw_a_din", Din, 32'hAAAA0007);
        chk("waw_a_wren", {31'd0, WrEn}, 32'd1);
        @(posedge Clk);
        @(negedge Clk);
        #1 chk("waw_b_rdy", {31'd0, ReqB_Ready}, 32'd1);
        @(posedge Clk);
        @(negedge Clk);
        ReqB_Valid = 1'b0;
        #1;
        chk("waw_b_pend", Pending, 32'h0000_0080);
        chk("waw_b_wren0", {31'd0, WrEn}, 32'd0);
        @(posedge Clk);
        @(negedge Clk);
        #1;
        chk("waw_b_wren", {31'd0, WrEn}, 32'd1);
        chk("waw_b_awr", {27'd0, Awr}, 32'd7);
        chk("waw_b_din", Din, 32'hBBBB0007);
        @(posedge Clk);
        @(negedge Clk);
        #1 chk("waw_pend_clr", Pending, 32'd0);

        // Same-cycle collision on R9
        ReqA_Valid = 1'b1; ReqA_Addr = 5'd9; ReqA_Data = 32'h9A;
        ReqB_Valid = 1'b1; ReqB_Addr = 5'd9; ReqB_Data = 32'h9B;
        #1;
        chk("col_ready", {30'd0, ReqA_Ready, ReqB_Ready}, 32'd2);
        @(posedge Clk);
        @(negedge Clk);
        ReqA_Valid = 1'b0;
        #1 chk("col_b_blk", {31'd0, ReqB_Ready}, 32'd0);
        @(posedge Clk);
        @(negedge Clk);
        #1 chk("col_a_din", Din, 32'h9A);
        idle_reqs();
        repeat (3) @(negedge Clk);

        // Reset mid-operation with both buffers full and a write staged
        ReqA_Valid = 1'b1; ReqA_Addr = 5'd12; ReqA_Data = 32'h12;
        ReqB_Valid = 1'b1; ReqB_Addr = 5'd13; ReqB_Data = 32'h13;
        @(posedge Clk);
        @(negedge Clk);
        ReqA_Addr = 5'd14; ReqA_Data = 32'h14;
        ReqB_Addr = 5'd15; ReqB_Data = 32'h15;
        @(posedge Clk);
        @(negedge Clk);
        idle_reqs();
        #1 chk("mid_wren_pre", {31'd0, WrEn}, 32'd1);
        Rst_n = 1'b0;
        #1;
        chk("mid_wren", {31'd0, WrEn}, 32'd0);
        chk("mid_awr", {27'd0, Awr}, 32'd0);
        chk("mid_din", Din, 32'd0);
        chk("mid_pend", Pending, 32'd0);
        chk("mid_fwd", {30'd0, Fwd1, Fwd2}, 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            chk("mid_no_write", {31'd0, WrEn}, 32'd0);
        end
        chk("mid_pend_post", Pending, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
